// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the PC and the instruction
//                half of the IF/ID register, and talks to instruction memory
//                through a variable-latency request/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800,
    parameter logic [4:0]  HALT_OPC = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    input  logic        imem_hit,
    output logic [15:0] pc,
    output logic [15:0] instruction,
    output logic [15:0] inst_pc,
    output logic [15:0] pc_plus2,
    output logic        inst_valid,
    output logic        fetch_busy,
    output logic        icache_req,
    output logic        icache_hit
);

    localparam logic [1:0] c_stFetch  = 2'd0;
    localparam logic [1:0] c_stWait   = 2'd1;
    localparam logic [1:0] c_stHold   = 2'd2;
    localparam logic [1:0] c_stHalted = 2'd3;

    logic [1:0]  r_state;
    logic        r_pendValid;
    logic [15:0] r_pendPc;
    logic [15:0] r_holdData;

    logic        w_reqFetch;
    logic [15:0] w_delData;
    logic        w_delHalt;
    logic        w_deliver;
    logic        w_bubble;
    logic        w_loadPc;
    logic [15:0] w_target;
    logic [1:0]  w_nextState;
    logic        w_setPend;
    logic        w_clrPend;
    logic        w_capture;

    // A new request is only issued from FETCH when nothing blocks it
    assign w_reqFetch = (r_state == c_stFetch) && !stall && !redirect_valid;

    // Memory-side handshake: address is the PC, held stable while waiting
    assign imem_rd    = w_reqFetch || (r_state == c_stWait);
    assign imem_addr  = pc;
    assign fetch_busy = (r_state == c_stWait);
    assign icache_req = w_reqFetch;
    assign icache_hit = imem_done && imem_hit && w_reqFetch;

    // Data to deliver comes from the hold buffer when draining HOLD
    assign w_delData = (r_state == c_stHold) ? r_holdData : imem_data;
    assign w_delHalt = (w_delData[15:11] == HALT_OPC);

    // Next-state and action decode; redirect outranks stall and done
    always_comb begin
        w_deliver   = 1'b0;
        w_bubble    = 1'b0;
        w_loadPc    = 1'b0;
        w_target    = redirect_pc;
        w_nextState = r_state;
        w_setPend   = 1'b0;
        w_clrPend   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            c_stFetch: begin
                if (redirect_valid) begin
                    w_loadPc = 1'b1;
                    w_bubble = 1'b1;
                end else if (!stall) begin
                    if (imem_done) begin
                        w_deliver = 1'b1;
                    end else begin
                        w_nextState = c_stWait;
                        w_bubble    = 1'b1;
                    end
                end
            end
            c_stWait: begin
                if (imem_done && (redirect_valid || r_pendValid)) begin
                    // Returned data belongs to a squashed path: drop it
                    w_loadPc    = 1'b1;
                    w_target    = redirect_valid ? redirect_pc : r_pendPc;
                    w_clrPend   = 1'b1;
                    w_nextState = c_stFetch;
                    w_bubble    = 1'b1;
                end else if (redirect_valid) begin
                    // Keep the address stable until memory answers
                    w_setPend = 1'b1;
                    w_bubble  = 1'b1;
                end else if (imem_done && stall) begin
                    w_capture   = 1'b1;
                    w_nextState = c_stHold;
                end else if (imem_done) begin
                    w_deliver = 1'b1;
                end else if (!stall) begin
                    w_bubble = 1'b1;
                end
            end
            c_stHold: begin
                if (redirect_valid) begin
                    w_loadPc    = 1'b1;
                    w_nextState = c_stFetch;
                    w_bubble    = 1'b1;
                end else if (!stall) begin
                    w_deliver = 1'b1;
                end
            end
            c_stHalted: begin
                if (redirect_valid) begin
                    w_loadPc    = 1'b1;
                    w_nextState = c_stFetch;
                    w_bubble    = 1'b1;
                end else if (!stall) begin
                    w_bubble = 1'b1;
                end
            end
            default: begin
                w_nextState = c_stFetch;
            end
        endcase
        if (w_deliver) begin
            w_nextState = w_delHalt ? c_stHalted : c_stFetch;
        end
    end

    // PC and state; a halt is delivered without advancing the PC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_stFetch;
            pc      <= RESET_PC;
        end else begin
            r_state <= w_nextState;
            if (w_loadPc) begin
                pc <= w_target;
            end else if (w_deliver && !w_delHalt) begin
                pc <= pc + 16'd2;
            end
        end
    end

    // IF/ID register: deliver, bubble, or hold
    always_ff @(posedge clk) begin
        if (rst) begin
            instruction <= NOP_INST;
            inst_pc     <= 16'h0000;
            pc_plus2    <= 16'h0000;
            inst_valid  <= 1'b0;
        end else if (w_deliver) begin
            instruction <= w_delData;
            inst_pc     <= pc;
            pc_plus2    <= pc + 16'd2;
            inst_valid  <= 1'b1;
        end else if (w_bubble) begin
            instruction <= NOP_INST;
            inst_valid  <= 1'b0;
        end
    end

    // Pending-redirect register and stalled-data hold buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pendValid <= 1'b0;
            r_pendPc    <= 16'h0000;
            r_holdData  <= 16'h0000;
        end else begin
            if (w_setPend) begin
                r_pendValid <= 1'b1;
                r_pendPc    <= redirect_pc;
            end else if (w_clrPend) begin
                r_pendValid <= 1'b0;
            end
            if (w_capture) begin
                r_holdData <= imem_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_done;
    logic        imem_hit;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic [15:0] inst_pc;
    logic [15:0] pc_plus2;
    logic        inst_valid;
    logic        fetch_busy;
    logic        icache_req;
    logic        icache_hit;

    int checks;
    int failures;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_rd        (imem_rd),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .imem_done      (imem_done),
        .imem_hit       (imem_hit),
        .pc             (pc),
        .instruction    (instruction),
        .inst_pc        (inst_pc),
        .pc_plus2       (pc_plus2),
        .inst_valid     (inst_valid),
        .fetch_busy     (fetch_busy),
        .icache_req     (icache_req),
        .icache_hit     (icache_hit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change on the falling edge, combinational outputs settle 1 later
    task automatic setIn(input logic r, input logic s, input logic rv, input logic [15:0] rp,
                         input logic d, input logic h, input logic [15:0] dat);
        @(negedge clk);
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
        imem_done = d; imem_hit = h; imem_data = dat;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        setIn(1, 0, 0, 16'h0, 0, 0, 16'h0);
        tick();
        checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 16'h0000); end
        checks++; if (instruction !== 16'h0800) begin failures++; $display("FAIL reset_inst got=%h exp=%h", instruction, 16'h0800); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
        checks++; if (inst_pc !== 16'h0000 || pc_plus2 !== 16'h0000) begin failures++; $display("FAIL reset_ifid got=%h/%h exp=0000/0000", inst_pc, pc_plus2); end
    endtask

    task automatic test_hits();
        for (int i = 0; i < 3; i++) begin
            logic [15:0] a;
            logic [15:0] d;
            a = 16'(2 * i);
            d = 16'h1000 + 16'(i);
            setIn(0, 0, 0, 16'h0, 1, 1, d);
            checks++; if (imem_rd !== 1'b1 || imem_addr !== a) begin failures++; $display("FAIL hit_req%0d got rd=%b addr=%h exp rd=1 addr=%h", i, imem_rd, imem_addr, a); end
            checks++; if (icache_req !== 1'b1 || icache_hit !== 1'b1 || fetch_busy !== 1'b0) begin failures++; $display("FAIL hit_strobe%0d got req=%b hit=%b busy=%b exp 1/1/0", i, icache_req, icache_hit, fetch_busy); end
            tick();
            checks++; if (instruction !== d || inst_valid !== 1'b1) begin failures++; $display("FAIL hit_inst%0d got=%h v=%b exp=%h v=1", i, instruction, inst_valid, d); end
            checks++; if (inst_pc !== a || pc_plus2 !== a + 16'd2 || pc !== a + 16'd2) begin failures++; $display("FAIL hit_pcs%0d got inst_pc=%h p2=%h pc=%h exp %h/%h/%h", i, inst_pc, pc_plus2, pc, a, a + 16'd2, a + 16'd2); end
        end
    endtask

    task automatic test_miss();
        setIn(0, 0, 1, 16'h0010, 0, 0, 16'h0);
        tick();
        checks++; if (pc !== 16'h0010 || inst_valid !== 1'b0) begin failures++; $display("FAIL miss_redir got pc=%h v=%b exp 0010 v=0", pc, inst_valid); end
        setIn(0, 0, 0, 16'h0, 0, 0, 16'h0);
        checks++; if (imem_addr !== 16'h0010 || icache_req !== 1'b1 || icache_hit !== 1'b0) begin failures++; $display("FAIL miss_c1 got addr=%h req=%b hit=%b exp 0010/1/0", imem_addr, icache_req, icache_hit); end
        tick();
        checks++; if (instruction !== 16'h0800 || inst_valid !== 1'b0) begin failures++; $display("FAIL miss_bub1 got=%h v=%b exp 0800 v=0", instruction, inst_valid); end
        setIn(0, 0, 0, 16'h0, 0, 0, 16'h0);
        checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0010 || fetch_busy !== 1'b1 || icache_req !== 1'b0) begin failures++; $display("FAIL miss_c2 got rd=%b addr=%h busy=%b req=%b exp 1/0010/1/0", imem_rd, imem_addr, fetch_busy, icache_req); end
        tick();
        checks++; if (instruction !== 16'h0800 || inst_valid !== 1'b0) begin failures++; $display("FAIL miss_bub2 got=%h v=%b exp 0800 v=0", instruction, inst_valid); end
        setIn(0, 0, 0, 16'h0, 1, 0, 16'h2000);
        checks++; if (imem_addr !== 16'h0010 || fetch_busy !== 1'b1 || icache_req !== 1'b0 || icache_hit !== 1'b0) begin failures++; $display("FAIL miss_c3 got addr=%h busy=%b req=%b hit=%b exp 0010/1/0/0", imem_addr, fetch_busy, icache_req, icache_hit); end
        tick();
        checks++; if (instruction !== 16'h2000 || inst_valid !== 1'b1 || inst_pc !== 16'h0010 || pc !== 16'h0012) begin failures++; $display("FAIL miss_deliver got inst=%h v=%b ipc=%h pc=%h exp 2000/1/0010/0012", instruction, inst_valid, inst_pc, pc); end
    endtask

    task automatic test_stall_hold();
        setIn(0, 0, 0, 16'h0, 0, 0, 16'h0);
        tick();
        setIn(0, 1, 0, 16'h0, 1, 0, 16'h3000);
        tick();
        checks++; if (instruction !== 16'h0800 || inst_valid !== 1'b0 || inst_pc !== 16'h0010) begin failures++; $display("FAIL hold_s1 got inst=%h v=%b ipc=%h exp 0800/0/0010", instruction, inst_valid, inst_pc); end
        setIn(0, 1, 0, 16'h0, 0, 0, 16'h0);
        checks++; if (imem_rd !== 1'b0 || icache_req !== 1'b0) begin failures++; $display("FAIL hold_noreq got rd=%b req=%b exp 0/0", imem_rd, icache_req); end
        tick();
        checks++; if (instruction !== 16'h0800 || inst_pc !== 16'h0010 || pc !== 16'h0012) begin failures++; $display("FAIL hold_s2 got inst=%h ipc=%h pc=%h exp 0800/0010/0012", instruction, inst_pc, pc); end
        setIn(0, 0, 0, 16'h0, 0, 0, 16'hDEAD);
        checks++; if (imem_rd !== 1'b0 || icache_req !== 1'b0) begin failures++; $display("FAIL hold_rel_noreq got rd=%b req=%b exp 0/0", imem_rd, icache_req); end
        tick();
        checks++; if (instruction !== 16'h3000 || inst_valid !== 1'b1 || inst_pc !== 16'h0012 || pc !== 16'h0014) begin failures++; $display("FAIL hold_deliver got inst=%h v=%b ipc=%h pc=%h exp 3000/1/0012/0014", instruction, inst_valid, inst_pc, pc); end
    endtask

    task automatic test_redirect_wait();
        setIn(0, 0, 1, 16'h0020, 0, 0, 16'h0);
        tick();
        setIn(0, 0, 0, 16'h0, 0, 0, 16'h0);
        tick();
        setIn(0, 1, 1, 16'h0040, 0, 0, 16'h0);
        checks++; if (imem_addr !== 16'h0020 || fetch_busy !== 1'b1) begin failures++; $display("FAIL rw_addr got addr=%h busy=%b exp 0020/1", imem_addr, fetch_busy); end
        tick();
        checks++; if (pc !== 16'h0020 || inst_valid !== 1'b0) begin failures++; $display("FAIL rw_pend got pc=%h v=%b exp 0020/0", pc, inst_valid); end
        setIn(0, 0, 0, 16'h0, 1, 0, 16'h4444);
        tick();
        checks++; if (pc !== 16'h0040 || inst_valid !== 1'b0 || instruction !== 16'h0800) begin failures++; $display("FAIL rw_drop got pc=%h v=%b inst=%h exp 0040/0/0800", pc, inst_valid, instruction); end
        setIn(0, 0, 0, 16'h0, 1, 1, 16'h5000);
        checks++; if (imem_addr !== 16'h0040 || icache_req !== 1'b1) begin failures++; $display("FAIL rw_newreq got addr=%h req=%b exp 0040/1", imem_addr, icache_req); end
        tick();
        checks++; if (instruction !== 16'h5000 || inst_pc !== 16'h0040 || inst_valid !== 1'b1) begin failures++; $display("FAIL rw_deliver got inst=%h ipc=%h v=%b exp 5000/0040/1", instruction, inst_pc, inst_valid); end
    endtask

    task automatic test_halt();
        setIn(0, 0, 1, 16'h0008, 0, 0, 16'h0);
        tick();
        setIn(0, 0, 0, 16'h0, 1, 1, 16'h0000);
        tick();
        checks++; if (instruction !== 16'h0000 || inst_valid !== 1'b1 || inst_pc !== 16'h0008 || pc !== 16'h0008) begin failures++; $display("FAIL halt_deliver got inst=%h v=%b ipc=%h pc=%h exp 0000/1/0008/0008", instruction, inst_valid, inst_pc, pc); end
        setIn(0, 0, 0, 16'h0, 1, 1, 16'h1111);
        checks++; if (imem_rd !== 1'b0 || icache_req !== 1'b0 || icache_hit !== 1'b0) begin failures++; $display("FAIL halt_norq got rd=%b req=%b hit=%b exp 0/0/0", imem_rd, icache_req, icache_hit); end
        tick();
        checks++; if (inst_valid !== 1'b0 || pc !== 16'h0008) begin failures++; $display("FAIL halt_bubble got v=%b pc=%h exp 0/0008", inst_valid, pc); end
        setIn(0, 0, 1, 16'h0100, 0, 0, 16'h0);
        tick();
        setIn(0, 0, 0, 16'h0, 1, 1, 16'h1234);
        checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0100) begin failures++; $display("FAIL halt_resume got rd=%b addr=%h exp 1/0100", imem_rd, imem_addr); end
        tick();
    endtask

    task automatic test_wrap_and_stall();
        setIn(0, 0, 1, 16'hFFFE, 0, 0, 16'h0);
        tick();
        setIn(0, 0, 0, 16'h0, 1, 1, 16'h1234);
        tick();
        checks++; if (pc !== 16'h0000 || inst_pc !== 16'hFFFE || pc_plus2 !== 16'h0000 || instruction !== 16'h1234) begin failures++; $display("FAIL wrap got pc=%h ipc=%h p2=%h inst=%h exp 0000/FFFE/0000/1234", pc, inst_pc, pc_plus2, instruction); end
        setIn(0, 1, 0, 16'h0, 1, 1, 16'h5555);
        checks++; if (imem_rd !== 1'b0 || icache_req !== 1'b0 || icache_hit !== 1'b0) begin failures++; $display("FAIL fstall_noreq got rd=%b req=%b hit=%b exp 0/0/0", imem_rd, icache_req, icache_hit); end
        tick();
        checks++; if (instruction !== 16'h1234 || inst_valid !== 1'b1 || pc !== 16'h0000) begin failures++; $display("FAIL fstall_hold got inst=%h v=%b pc=%h exp 1234/1/0000", instruction, inst_valid, pc); end
    endtask

    task automatic test_reset_mid();
        setIn(0, 0, 1, 16'h0030, 0, 0, 16'h0);
        tick();
        setIn(0, 0, 0, 16'h0, 0, 0, 16'h0);
        tick();
        setIn(1, 1, 1, 16'h0077, 1, 1, 16'h9999);
        tick();
        checks++; if (pc !== 16'h0000 || instruction !== 16'h0800 || inst_valid !== 1'b0 || inst_pc !== 16'h0000) begin failures++; $display("FAIL rstmid got pc=%h inst=%h v=%b ipc=%h exp 0000/0800/0/0000", pc, instruction, inst_valid, inst_pc); end
        setIn(0, 0, 0, 16'h0, 0, 0, 16'h0);
        checks++; if (imem_rd !== 1'b1 || icache_req !== 1'b1 || fetch_busy !== 1'b0 || imem_addr !== 16'h0000) begin failures++; $display("FAIL rstmid_fetch got rd=%b req=%b busy=%b addr=%h exp 1/1/0/0000", imem_rd, icache_req, fetch_busy, imem_addr); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
        imem_done = 1'b0; imem_hit = 1'b0; imem_data = 16'h0;
        test_reset();
        test_hits();
        test_miss();
        test_stall_hold();
        test_redirect_wait();
        test_halt();
        test_wrap_and_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
